// File: rtl/sram_bist_ctrl_if.sv
// +--------------------------------------------------------------------+
// | sram_bist_ctrl_if : BIST handshake, status and SRAM bus bundle     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface sram_bist_ctrl_if;
  logic        bist_start;
  logic        bist_gnt;
  logic        bist_req;
  logic        bist_busy;
  logic        bist_done;
  logic        bist_fail;
  logic [13:0] fail_addr;
  logic [2:0]  fail_elem;
  logic [31:0] fail_xor;
  logic [7:0]  sram_q0;
  logic [7:0]  sram_q1;
  logic [7:0]  sram_q2;
  logic [7:0]  sram_q3;
  logic [7:0]  sram_q4;
  logic [7:0]  sram_q5;
  logic [7:0]  sram_q6;
  logic [7:0]  sram_q7;
  logic [3:0]  bank0_c_sn;
  logic [3:0]  bank1_c_sn;
  logic        sram_w_en;
  logic        sram_o_en;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;

  modport master (
    input  bist_start, bist_gnt,
    input  sram_q0, sram_q1, sram_q2, sram_q3, sram_q4, sram_q5, sram_q6, sram_q7,
    output bist_req, bist_busy, bist_done, bist_fail,
    output fail_addr, fail_elem, fail_xor,
    output bank0_c_sn, bank1_c_sn, sram_w_en, sram_o_en, sram_addr, sram_wdata
  );

  modport slave (
    output bist_start, bist_gnt,
    output sram_q0, sram_q1, sram_q2, sram_q3, sram_q4, sram_q5, sram_q6, sram_q7,
    input  bist_req, bist_busy, bist_done, bist_fail,
    input  fail_addr, fail_elem, fail_xor,
    input  bank0_c_sn, bank1_c_sn, sram_w_en, sram_o_en, sram_addr, sram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_bist_ctrl.sv
// +--------------------------------------------------------------------+
// | sram_bist_ctrl : March C- BIST controller for the two-bank SRAM    |
// | Optional first-fail diagnostics: define SRAM_BIST_DIAG_EN          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sram_bist_ctrl #(
  parameter logic [12:0] MAX_ADDR = 13'h1FFF
) (
  input  logic             hclk,
  input  logic             hresetn,
  sram_bist_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [13:0] IDX_FIRST = 14'h0000;
  localparam logic [13:0] IDX_LAST  = {1'b1, MAX_ADDR};

  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic        phase_q, phase_d;
  logic [13:0] idx_q, idx_d;
  logic [12:0] addr_hold_q;
  logic [31:0] wdata_hold_q;
  logic        rd_pend_q;
  logic        rd_exp_q;
  logic        rd_bank_q;
  logic        fail_q;

  logic        w_start;
  logic        w_active;
  logic        w_two_op;
  logic        w_is_read;
  logic        w_desc;
  logic        w_data_one;
  logic        w_step;
  logic        w_last;
  logic [13:0] w_idx_next;
  logic [31:0] w_rd_word;
  logic [31:0] w_rd_xor;
  logic        w_mismatch;

  assign w_start    = (state_q == S_IDLE) && bus.bist_start;
  assign w_active   = (state_q == S_RUN) && bus.bist_gnt;
  assign w_two_op   = (elem_q != 3'd0) && (elem_q != 3'd5);
  assign w_is_read  = w_two_op ? !phase_q : (elem_q == 3'd5);
  assign w_desc     = (elem_q == 3'd3) || (elem_q == 3'd4);
  // Reads expect what the previous element wrote; writes store the complement.
  assign w_data_one = w_is_read ? ((elem_q == 3'd2) || (elem_q == 3'd4))
                                : ((elem_q == 3'd1) || (elem_q == 3'd3));
  assign w_step     = !w_two_op || phase_q;
  assign w_last     = w_desc ? (idx_q == IDX_FIRST) : (idx_q == IDX_LAST);

  always_comb begin
    w_idx_next = idx_q;
    if (w_desc) begin
      w_idx_next = (idx_q[12:0] == 13'h0) ? {1'b0, MAX_ADDR} : (idx_q - 14'd1);
    end else begin
      w_idx_next = (idx_q[12:0] == MAX_ADDR) ? {1'b1, 13'h0} : (idx_q + 14'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.bist_start) begin
          state_d = S_REQ;
          elem_d  = 3'd0;
          phase_d = 1'b0;
          idx_d   = IDX_FIRST;
        end
      end
      S_REQ: begin
        if (bus.bist_gnt) state_d = S_RUN;
      end
      S_RUN: begin
        // Without grant nothing advances, so a split r,w pair resumes at the w.
        if (bus.bist_gnt) begin
          if (w_two_op) phase_d = !phase_q;
          if (w_step) begin
            if (!w_last) begin
              idx_d = w_idx_next;
            end else if (elem_q == 3'd5) begin
              state_d = S_CHECK;
            end else begin
              elem_d = elem_q + 3'd1;
              idx_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? IDX_LAST : IDX_FIRST;
            end
          end
        end
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      phase_q <= 1'b0;
      idx_q   <= 14'h0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Read data arrives one cycle after the read and is checked regardless of grant.
  assign w_rd_word  = rd_bank_q ? {bus.sram_q7, bus.sram_q6, bus.sram_q5, bus.sram_q4}
                                : {bus.sram_q3, bus.sram_q2, bus.sram_q1, bus.sram_q0};
  assign w_rd_xor   = w_rd_word ^ {32{rd_exp_q}};
  assign w_mismatch = rd_pend_q && (|w_rd_xor);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_hold_q  <= 13'h0;
      wdata_hold_q <= 32'h0;
      rd_pend_q    <= 1'b0;
      rd_exp_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      if (w_active) addr_hold_q <= idx_q[12:0];
      if (w_active && !w_is_read) wdata_hold_q <= {32{w_data_one}};
      rd_pend_q <= w_active && w_is_read;
      if (w_active && w_is_read) begin
        rd_exp_q  <= w_data_one;
        rd_bank_q <= idx_q[13];
      end
      if (w_start) begin
        fail_q <= 1'b0;
      end else if (w_mismatch) begin
        fail_q <= 1'b1;
      end
    end
  end

`ifdef SRAM_BIST_DIAG_EN
  logic [13:0] rd_idx_q;
  logic [2:0]  rd_elem_q;
  logic [13:0] fail_addr_q;
  logic [2:0]  fail_elem_q;
  logic [31:0] fail_xor_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_idx_q    <= 14'h0;
      rd_elem_q   <= 3'd0;
      fail_addr_q <= 14'h0;
      fail_elem_q <= 3'd0;
      fail_xor_q  <= 32'h0;
    end else begin
      if (w_active && w_is_read) begin
        rd_idx_q  <= idx_q;
        rd_elem_q <= elem_q;
      end
      if (w_start) begin
        fail_addr_q <= 14'h0;
        fail_elem_q <= 3'd0;
        fail_xor_q  <= 32'h0;
      end else if (w_mismatch && !fail_q) begin
        fail_addr_q <= rd_idx_q;
        fail_elem_q <= rd_elem_q;
        fail_xor_q  <= w_rd_xor;
      end
    end
  end

  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
  assign bus.fail_xor  = fail_xor_q;
`else
  assign bus.fail_addr = 14'h0;
  assign bus.fail_elem = 3'd0;
  assign bus.fail_xor  = 32'h0;
`endif

  assign bus.bist_req   = (state_q == S_REQ) || (state_q == S_RUN) || (state_q == S_CHECK);
  assign bus.bist_busy  = (state_q != S_IDLE);
  assign bus.bist_done  = (state_q == S_DONE);
  assign bus.bist_fail  = fail_q;
  assign bus.bank0_c_sn = (w_active && !idx_q[13]) ? 4'h0 : 4'hF;
  assign bus.bank1_c_sn = (w_active &&  idx_q[13]) ? 4'h0 : 4'hF;
  assign bus.sram_w_en  = !(w_active && !w_is_read);
  assign bus.sram_o_en  = !(((state_q == S_RUN) || (state_q == S_CHECK)) && bus.bist_gnt);
  assign bus.sram_addr  = w_active ? idx_q[12:0] : addr_hold_q;
  assign bus.sram_wdata = (w_active && !w_is_read) ? {32{w_data_one}} : wdata_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bist_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_sram_bist_ctrl : bench for sram_bist_ctrl with MAX_ADDR = 3     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sram_bist_ctrl;

  typedef struct packed {
    logic        wr;
    logic        bank;
    logic [12:0] addr;
    logic [31:0] data;
  } op_t;

`ifdef SRAM_BIST_DIAG_EN
  localparam logic [13:0] FLT_ADDR = 14'h2002;
  localparam logic [2:0]  FLT_ELEM = 3'd1;
  localparam logic [31:0] FLT_XOR  = 32'h0000_0020;
`else
  localparam logic [13:0] FLT_ADDR = 14'h0;
  localparam logic [2:0]  FLT_ELEM = 3'd0;
  localparam logic [31:0] FLT_XOR  = 32'h0;
`endif

  logic hclk;
  logic hresetn;
  int   total;
  int   bad;
  bit   fault_en;
  op_t  sb[$];

  logic [31:0] mem [0:7];
  logic [31:0] rd0_q;
  logic [31:0] rd1_q;

  sram_bist_ctrl_if bus();

  sram_bist_ctrl #(.MAX_ADDR(13'd3)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Two-bank SRAM with one-cycle read latency; optional stuck-at-1 on bank1 word 2 bit 5.
  always @(posedge hclk) begin
    if (bus.bank0_c_sn == 4'h0) begin
      if (!bus.sram_w_en) mem[{1'b0, bus.sram_addr[1:0]}] <= bus.sram_wdata;
      else rd0_q <= mem[{1'b0, bus.sram_addr[1:0]}];
    end
    if (bus.bank1_c_sn == 4'h0) begin
      if (!bus.sram_w_en) mem[{1'b1, bus.sram_addr[1:0]}] <= bus.sram_wdata;
      else rd1_q <= mem[{1'b1, bus.sram_addr[1:0]}] |
                    ((fault_en && bus.sram_addr[1:0] == 2'd2) ? 32'h20 : 32'h0);
    end
  end

  assign {bus.sram_q3, bus.sram_q2, bus.sram_q1, bus.sram_q0} = rd0_q;
  assign {bus.sram_q7, bus.sram_q6, bus.sram_q5, bus.sram_q4} = rd1_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"},
        64'({bus.bist_req, bus.bist_busy, bus.bist_done, bus.bist_fail,
             bus.bank0_c_sn, bus.bank1_c_sn, bus.sram_w_en, bus.sram_o_en,
             bus.sram_addr, bus.sram_wdata}),
        64'({4'b0000, 8'hFF, 2'b11, 13'h0, 32'h0}));
    chk({tag, "_diag"}, 64'({bus.fail_addr, bus.fail_elem, bus.fail_xor}), 64'(0));
  endtask

  // Expected March C- op stream for 2 banks x 4 words, pushed when a run starts.
  task automatic push_ops();
    sb.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 8; k++) begin
        int          i;
        logic [31:0] wv;
        i  = (e == 3 || e == 4) ? 7 - k : k;
        wv = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
        if (e != 0) sb.push_back('{1'b0, i[2], {11'd0, i[1:0]}, 32'h0});
        if (e != 5) sb.push_back('{1'b1, i[2], {11'd0, i[1:0]}, wv});
      end
    end
  endtask

  task automatic run_test(input int gnt_lo, input int gnt_hi, input int done_cyc,
                          input int restart_cyc, input int abort_cyc, input bit fault,
                          input bit exp_fail, input logic [13:0] e_addr,
                          input logic [2:0] e_elem, input logic [31:0] e_xor);
    op_t         e;
    logic [63:0] obs;
    logic [63:0] expv;
    fault_en = fault;
    push_ops();
    for (int c = 0; c <= done_cyc + 2; c++) begin
      if (c > 0) begin
        @(posedge hclk);
        #1;
      end
      bus.bist_start = (c == 0) || (c == restart_cyc);
      bus.bist_gnt   = !(c >= gnt_lo && c <= gnt_hi);
      #1;
      if (c == abort_cyc) begin
        hresetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge hclk);
        #1;
        hresetn        = 1'b1;
        bus.bist_start = 1'b0;
        bus.bist_gnt   = 1'b1;
        return;
      end
      chk("status", 64'({bus.bist_req, bus.bist_busy, bus.bist_done}),
          64'({c >= 1 && c < done_cyc, c >= 1 && c <= done_cyc, c == done_cyc}));
      if (!bus.bist_gnt)
        chk("nognt_bus", 64'({bus.bank0_c_sn, bus.bank1_c_sn, bus.sram_w_en, bus.sram_o_en}),
            64'({8'hFF, 2'b11}));
      if (bus.bank0_c_sn != 4'hF || bus.bank1_c_sn != 4'hF) begin
        obs = 64'({!bus.sram_w_en, bus.bank0_c_sn, bus.bank1_c_sn, bus.sram_addr,
                   (!bus.sram_w_en) ? bus.sram_wdata : 32'h0});
        if (sb.size() > 0) begin
          e    = sb.pop_front();
          expv = 64'({e.wr, e.bank ? 4'hF : 4'h0, e.bank ? 4'h0 : 4'hF, e.addr, e.data});
        end else begin
          expv = 64'({1'b0, 8'hFF, 13'h0, 32'h0});
        end
        chk("op", obs, expv);
      end
      if (c == 1)
        chk("fail_clr", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem, bus.fail_xor}), 64'(0));
      if (c == done_cyc)
        chk("result", 64'({bus.bist_fail, bus.fail_addr, bus.fail_elem, bus.fail_xor}),
            64'({exp_fail, e_addr, e_elem, e_xor}));
    end
    chk("ops_left", 64'(sb.size()), 64'(0));
    bus.bist_start = 1'b0;
    bus.bist_gnt   = 1'b1;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    fault_en       = 1'b0;
    hresetn        = 1'b0;
    bus.bist_start = 1'b0;
    bus.bist_gnt   = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    check_reset_outputs("reset");
    hresetn = 1'b1;
    repeat (2) @(posedge hclk);
    #1;

    // Clean run with grant held.
    run_test(-1, -1, 83, -1, -1, 1'b0, 1'b0, 14'h0, 3'd0, 32'h0);
    // Stuck-at-1 on bank1 addr2 bit5; run still completes on time.
    run_test(-1, -1, 83, -1, -1, 1'b1, 1'b1, FLT_ADDR, FLT_ELEM, FLT_XOR);
    // Grant withheld for 10 cycles after start; fail state cleared by start.
    run_test(1, 10, 93, -1, -1, 1'b0, 1'b0, 14'h0, 3'd0, 32'h0);
    // Grant drop splitting an M2 r,w pair, plus an ignored start while busy.
    run_test(31, 35, 88, 50, -1, 1'b0, 1'b0, 14'h0, 3'd0, 32'h0);
    // Reset pulsed mid-run during M1, then a fresh clean run.
    run_test(-1, -1, 83, -1, 20, 1'b0, 1'b0, 14'h0, 3'd0, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    run_test(-1, -1, 83, -1, -1, 1'b0, 1'b0, 14'h0, 3'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
